// File: rtl/paced_counter_pkg.sv
// rtl/paced_counter_pkg.sv - shared encodings and parameter helpers for paced_counter
package paced_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return (tick_hz > 0) ? clk_hz / tick_hz : 0;
  endfunction

  function automatic int pcnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic bit div_ok(input int clk_hz, input int tick_hz);
    return (tick_hz > 0) && (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2);
  endfunction

endpackage

// File: rtl/paced_counter_tick_gen.sv
// rtl/paced_counter_tick_gen.sv - prescaler emitting a one-cycle tick every DIV clocks
module tick_gen
  import paced_counter_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = pcnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt == LAST) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/paced_counter.sv
// rtl/paced_counter.sv - prescaled up/down counter with terminal value, wrap/saturate and tc pulse
module paced_counter
  import paced_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int MAX     = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  generate
    if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
      $error("paced_counter: CLK_HZ/TICK_HZ must be an integer ratio of at least 2");
    end
    if (MAX <= 0 || MAX > 2**WIDTH - 1) begin : g_bad_max
      $error("paced_counter: MAX must lie in 1..2**WIDTH-1");
    end
  endgenerate

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  logic [WIDTH-1:0] step_q;
  logic             at_limit;

  // Next value for a step; at the limit the mode decides between wrap and pin.
  always_comb begin
    step_q   = q;
    at_limit = 1'b0;
    if (dir == DIR_UP) begin
      at_limit = (q == MAX_V);
      if (!at_limit)           step_q = q + WIDTH'(1);
      else if (mode != MODE_SAT) step_q = '0;
    end else begin
      at_limit = (q == '0);
      if (!at_limit)           step_q = q - WIDTH'(1);
      else if (mode != MODE_SAT) step_q = MAX_V;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (clear) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= (load_val > MAX_V) ? MAX_V : load_val;
      tc <= 1'b0;
    end else if (tick && en) begin
      q  <= step_q;
      tc <= at_limit;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paced_counter.sv
// tb/tb_paced_counter.sv - randomized and directed checks of paced_counter against a behavioural model
module tb_paced_counter;

  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 2;
  localparam int DIV     = 4;
  localparam int WIDTH   = 4;
  localparam int MAX     = 9;

  logic clk = 1'b0;
  logic reset, clear, en, dir, mode, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic tick, tc;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edges since reset/clear, count value, current tick/tc outputs.
  int m_since;
  int m_q;
  bit m_tick;
  bit m_tc;

  always #5 clk = ~clk;

  paced_counter #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .WIDTH   (WIDTH),
    .MAX     (MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tick     (tick),
    .tc       (tc)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_since = 0;
    m_q     = 0;
    m_tick  = 1'b0;
    m_tc    = 1'b0;
  endtask

  task automatic model_edge();
    bit prev_tick;
    if (clear) begin
      model_reset();
    end else begin
      prev_tick = m_tick;
      m_since++;
      m_tick = (m_since % DIV == 0);
      if (load) begin
        m_q  = (int'(load_val) > MAX) ? MAX : int'(load_val);
        m_tc = 1'b0;
      end else if (prev_tick && en) begin
        if (dir) begin
          m_tc = (m_q == MAX);
          if (!(mode && m_tc)) m_q = (m_q + 1) % (MAX + 1);
        end else begin
          m_tc = (m_q == 0);
          if (!(mode && m_tc)) m_q = (m_q + MAX) % (MAX + 1);
        end
      end else begin
        m_tc = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_val("q", q, m_q);
    check_val("tick", tick, m_tick);
    check_val("tc", tc, m_tc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the next edge will sample tick high.
  task automatic to_tick_edge();
    for (int i = 0; i < 2 * DIV; i++) begin
      if (m_tick) return;
      cycle();
    end
    check_val("tick_timeout", 0, 1);
  endtask

  int tc_count;

  initial begin
    reset = 1'b0; clear = 1'b0; en = 1'b0; dir = 1'b1; mode = 1'b0;
    load = 1'b0; load_val = '0;
    model_reset();
    run(2);
    reset = 1'b1; en = 1'b1; dir = 1'b1; mode = 1'b0;
    run(10);
    check_val("first_run_q", q, 2);

    load = 1'b1; load_val = 4'd9;
    cycle();
    load = 1'b0;
    to_tick_edge();
    cycle();
    check_val("wrap_up_q", q, 0);
    check_val("wrap_up_tc", tc, 1);
    cycle();
    check_val("wrap_up_tc_once", tc, 0);

    dir = 1'b0;
    to_tick_edge();
    cycle();
    check_val("wrap_down_q", q, 9);
    check_val("wrap_down_tc", tc, 1);

    mode = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'd9;
    cycle();
    load = 1'b0;
    tc_count = 0;
    for (int k = 0; k < 3; k++) begin
      to_tick_edge();
      cycle();
      tc_count += int'(tc);
    end
    check_val("sat_tc_count", tc_count, 3);
    check_val("sat_q", q, 9);
    dir = 1'b0;
    to_tick_edge();
    cycle();
    check_val("sat_down_q", q, 8);
    check_val("sat_down_tc", tc, 0);

    mode = 1'b0; dir = 1'b1;
    to_tick_edge();
    load = 1'b1; load_val = 4'd15;
    cycle();
    load = 1'b0;
    check_val("clamp_q", q, 9);
    check_val("clamp_tc", tc, 0);

    for (int i = 0; i < 2 * DIV && (m_since % DIV) != 2; i++) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check_val("clear_q", q, 0);
    run(3);
    check_val("clear_no_early_tick", tick, 0);
    cycle();
    check_val("clear_tick_at_4", tick, 1);

    en = 1'b0;
    run(12);
    check_val("hold_q", q, 0);

    en = 1'b1;
    run(7);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_val("async_q", q, 0);
    check_val("async_tick", tick, 0);
    check_val("async_tc", tc, 0);
    run(2);
    reset = 1'b1;
    run(10);
    check_val("resume_q", q, 2);

    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      clear    = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/paced_counter.md
# paced_counter

Parametrised successor to the fixed 1 Hz divider and 4-bit ripple counter on the DE1_SoC top level. It combines a programmable tick prescaler (any CLK_HZ/TICK_HZ ratio) with a WIDTH-bit up/down counter. The counter adds a programmable terminal value, wrap or saturate mode, synchronous load and clear, and a terminal-count pulse. It sits between CLOCK_50 and the LEDR/HEX display logic and is fully synchronous to one clock; it no longer uses a derived `clk` as a clock.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, step rate. DIV = CLK_HZ/TICK_HZ; elaboration error if DIV < 2 or CLK_HZ % TICK_HZ != 0.
- WIDTH, 4, counter width.
- MAX, 2**WIDTH-1, terminal value. Elaboration error if MAX > 2**WIDTH-1 or MAX == 0.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- clear  in  1  synchronous clear of prescaler and count.
- en  in  1  count enable, sampled only on tick cycles.
- dir  in  1  1 = up, 0 = down.
- mode  in  1  0 = wrap, 1 = saturate.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load; values > MAX are clamped to MAX.
- q  out  WIDTH  count value.
- tick  out  1  one-cycle pulse, every DIV cycles.
- tc  out  1  one-cycle terminal-count pulse.

## Operation
- Prescaler pcnt counts 0..DIV-1, width $clog2(DIV). On the edge where pcnt == DIV-1: pcnt <= 0 and tick <= 1. Otherwise pcnt increments and tick <= 0.
- A step occurs on an edge where tick == 1 && en && !load && !clear.
- Priority per edge, highest first: reset (async), clear, load, step, hold.
- clear: pcnt <= 0, q <= 0, tick <= 0, tc <= 0.
- load: q <= min(load_val, MAX); tc <= 0; prescaler keeps running.
- Step, up: if q == MAX, q <= 0 in wrap mode or holds MAX in saturate mode, and tc <= 1. Otherwise q <= q+1.
- Step, down: if q == 0, q <= MAX in wrap mode or holds 0 in saturate mode, and tc <= 1. Otherwise q <= q-1.
- tc is 0 on every edge without an at-limit step. In saturate mode tc re-pulses on each tick while the counter is pinned at the limit with en high.
- dir and mode are sampled at the step edge; changing them between ticks has no side effects.

## Timing
- Reset values: q = 0, tick = 0, tc = 0, pcnt = 0. Reset is asynchronous on assertion; release is expected to be synchronised upstream.
- First tick is high in cycle DIV after reset release (or after clear), then every DIV cycles.
- Step latency: q updates on the edge that samples tick high, i.e. one cycle after tick rises. tc is high in the same cycle as the new q.
- load takes effect on the next edge (1-cycle latency). It overrides a coincident step, and that tick is consumed with no step.
- reset mid-count: all outputs return to reset values immediately, with no partial step.
- All outputs are registered, with no combinational input-to-output path.

## Structure
- Shared package paced_counter_pkg: mode encoding constants (MODE_WRAP = 0, MODE_SAT = 1), DIR_UP/DIR_DOWN, and a function computing DIV and prescaler width for parameter checks.
- One sub-module, tick_gen: the prescaler, parameterised by DIV, with ports clk, reset, clear, tick. It replaces the old clock_1_sec divider for all other consumers.
- The counter/limit logic lives in paced_counter itself.

## Test plan
Bench parameters are CLK_HZ=8, TICK_HZ=2 (DIV=4), WIDTH=4, MAX=9.
- Reset release, en=1, dir=1, mode=0: tick pulses at cycles 4, 8, 12, …; q = 1 at cycle 5, 2 at cycle 9; tc stays 0.
- Wrap up: load 9, en=1, dir=1: on the next step q = 0 and tc is high for exactly one cycle. Down from 0 with mode=0 gives q = 9 and a tc pulse.
- Saturate: mode=1, q=9, dir=1, three ticks: q stays 9 and tc pulses three times. Then dir=0: q = 8 with no tc.
- Load clamp and priority: load=1, load_val=15 coincident with tick and en: q = 9 next cycle, no step, tc = 0.
- clear mid-interval at pcnt=2: q = 0, and the next tick arrives 4 cycles after clear deasserts. en=0 across ticks holds q.
- Async reset asserted between clock edges mid-count: q, tick and tc go to 0 immediately without waiting for an edge. Counting resumes correctly after release.
